// File: rtl/controle_timer_pkg.sv
// controle_timer_pkg: shared types and constants for the microwave timer control unit.
//   state_t    : control FSM states (encoding is visible on the state output)
//   MAX_DIGITS : number of keypad digits the MM:SS timer accepts
//   DIGIT_MAX  : largest keypad code treated as a decimal digit
package controle_timer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned COUNT_W    = 2;
    localparam int unsigned MAX_DIGITS = 3;
    localparam int unsigned DIGIT_MAX  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        COOK  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // Keypad codes above 9 are function keys and never reach the timer.
    function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
        return code <= DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/controle_timer_tick.sv
// gerador_tick: once-per-second prescaler for the cooking countdown.
//   clk, reset : clock, asynchronous active-high reset
//   run        : count enable; the count holds its value while low
//   restart    : synchronously returns the count to 0 (fresh cook cycle)
//   tick       : high during the cycle in which the count sits at its terminal value while running
module gerador_tick #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart wins, otherwise wrap at the terminal value while running.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !restart && (cnt_q == TERMINAL);

endmodule

// File: rtl/controle_timer.sv
// controle_timer: control unit for the microwave MM:SS countdown timer.
//   TICKS_PER_SEC  : clk cycles per timer decrement (>= 2)
//   clk, reset     : clock, asynchronous active-high reset
//   key_valid      : one-cycle strobe, key_digit holds a keypad code (0-9 digits, 10-15 ignored)
//   startn/stopn/clearn : debounced active-low buttons
//   door_closed    : 1 = door shut
//   zero           : timer reads 0:00
//   timer_data     : last loaded digit, shifted in while timer_load_n is low
//   timer_load_n / timer_clear_n / timer_enable_n : active-low one-cycle timer strobes
//   mag_on         : magnetron enable
//   done           : one-cycle pulse when cooking finishes
//   state          : IDLE=0, SET=1, COOK=2, PAUSE=3
module controle_timer
    import controle_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               zero,
    output logic [DIGIT_W-1:0] timer_data,
    output logic               timer_load_n,
    output logic               timer_clear_n,
    output logic               timer_enable_n,
    output logic               mag_on,
    output logic               done,
    output logic [1:0]         state
);

    // Button bit order: {stop, clear, start}
    localparam int unsigned BTN_W = 3;

    logic [BTN_W-1:0]   btn_d, btn_q, btn_prev_q;
    logic               start_press, stop_press, clear_press;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] digits_q, digits_d;
    logic [DIGIT_W-1:0] data_q, data_d;
    logic               load_n_q, load_n_d;
    logic               clear_n_q, clear_n_d;
    logic               enable_n_q, enable_n_d;
    logic               mag_on_q, mag_on_d;
    logic               done_q, done_d;

    logic               key_ok;
    logic               run;
    logic               restart;
    logic               tick;

    // A press is the registered button copy falling 1->0; holding gives one press.
    assign btn_d       = {stopn, clearn, startn};
    assign start_press = btn_prev_q[0] & ~btn_q[0];
    assign clear_press = btn_prev_q[1] & ~btn_q[1];
    assign stop_press  = btn_prev_q[2] & ~btn_q[2];

    assign key_ok = key_valid && is_digit(key_digit);

    // The prescaler advances only in cycles where COOK is not being left, so a
    // pause holds the count exactly and a finishing cycle never decrements.
    assign run = (state_q == COOK) && door_closed && !stop_press && !zero;

    gerador_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .restart(restart),
        .tick   (tick)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        data_d     = data_q;
        load_n_d   = 1'b1;
        clear_n_d  = 1'b1;
        enable_n_d = 1'b1;
        done_d     = 1'b0;
        restart    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_ok) begin
                    data_d   = key_digit;
                    load_n_d = 1'b0;
                    digits_d = COUNT_W'(1);
                    state_d  = SET;
                end
            end

            SET: begin
                if (stop_press) begin
                    // Stop has no meaning while setting, but still outranks the rest.
                end else if (clear_press) begin
                    clear_n_d = 1'b0;
                    digits_d  = '0;
                    state_d   = IDLE;
                end else if (start_press && door_closed && !zero) begin
                    restart = 1'b1;
                    state_d = COOK;
                end else if (key_ok && (digits_q < COUNT_W'(MAX_DIGITS))) begin
                    data_d   = key_digit;
                    load_n_d = 1'b0;
                    digits_d = digits_q + COUNT_W'(1);
                end
            end

            COOK: begin
                if (!door_closed || stop_press) begin
                    state_d = PAUSE;
                end else if (zero) begin
                    done_d   = 1'b1;
                    digits_d = '0;
                    state_d  = IDLE;
                end else if (tick) begin
                    enable_n_d = 1'b0;
                end
            end

            PAUSE: begin
                if (!door_closed) begin
                    // Open door blocks every button; cooking cannot resume.
                end else if (stop_press || clear_press) begin
                    clear_n_d = 1'b0;
                    digits_d  = '0;
                    state_d   = IDLE;
                end else if (start_press) begin
                    state_d = COOK;
                end
            end

            default: state_d = IDLE;
        endcase

        mag_on_d = (state_d == COOK);
    end

    // State and output registers; timer_clear_n resets low so the timer starts at 0:00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            digits_q   <= '0;
            data_q     <= '0;
            load_n_q   <= 1'b1;
            clear_n_q  <= 1'b0;
            enable_n_q <= 1'b1;
            mag_on_q   <= 1'b0;
            done_q     <= 1'b0;
            btn_q      <= '1;
            btn_prev_q <= '1;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            data_q     <= data_d;
            load_n_q   <= load_n_d;
            clear_n_q  <= clear_n_d;
            enable_n_q <= enable_n_d;
            mag_on_q   <= mag_on_d;
            done_q     <= done_d;
            btn_q      <= btn_d;
            btn_prev_q <= btn_q;
        end
    end

    assign timer_data     = data_q;
    assign timer_load_n   = load_n_q;
    assign timer_clear_n  = clear_n_q;
    assign timer_enable_n = enable_n_q;
    assign mag_on         = mag_on_q;
    assign done           = done_q;
    assign state          = state_q;

endmodule

// File: tb/tb_controle_timer.sv
// tb_controle_timer: scoreboard bench for controle_timer with TICKS_PER_SEC=4.
// Timer strobes (load/clear/enable/done) are predicted with their cycle number
// when stimulus is driven and matched by a negedge monitor as the DUT emits them.
module tb_controle_timer;

    localparam int unsigned TPS = 4;

    localparam int EV_LOAD = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_EN   = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       clearn = 1'b1;
    logic       door_closed = 1'b1;
    logic       zero = 1'b1;
    logic [3:0] timer_data;
    logic       timer_load_n;
    logic       timer_clear_n;
    logic       timer_enable_n;
    logic       mag_on;
    logic       done;
    logic [1:0] state;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    ev_t  sb_q[$];

    controle_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_digit     (key_digit),
        .startn        (startn),
        .stopn         (stopn),
        .clearn        (clearn),
        .door_closed   (door_closed),
        .zero          (zero),
        .timer_data    (timer_data),
        .timer_load_n  (timer_load_n),
        .timer_clear_n (timer_clear_n),
        .timer_enable_n(timer_enable_n),
        .mag_on        (mag_on),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen; at a negedge it names the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag, input int kind, input int val);
        ev_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_unexpected"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_kind"}, kind, e.kind);
            chk({tag, "_cycle"}, cyc, e.cyc);
            chk({tag, "_value"}, val, e.val);
        end
    endtask

    // Monitor: every active strobe must match the oldest predicted event.
    always @(negedge clk) begin
        if (mon_on) begin
            if (!timer_load_n)   sb_pop("load", EV_LOAD, int'(timer_data));
            if (!timer_clear_n)  sb_pop("clear", EV_CLR, 0);
            if (!timer_enable_n) sb_pop("enable", EV_EN, 0);
            if (done)            sb_pop("done", EV_DONE, 0);
        end
    end

    // Moves to the drive point of the next cycle; inputs set here are sampled at edge cyc+1.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) next_cycle();
    endtask

    // Key strobe driven now is sampled at edge cyc+1 and loads in that cycle.
    task automatic press_key(input logic [3:0] d, input bit expect_load);
        next_cycle();
        key_valid = 1'b1;
        key_digit = d;
        if (expect_load) sb_push(EV_LOAD, int'(d), cyc + 1);
        next_cycle();
        key_valid = 1'b0;
    endtask

    // Holds a button low for two edges. Called at cyc c0: press detected at
    // edge c0+2, acted on at edge c0+3, task returns at cycle c0+3.
    task automatic push_button(input int which);
        next_cycle();
        case (which)
            0: startn = 1'b0;
            1: stopn  = 1'b0;
            default: clearn = 1'b0;
        endcase
        next_cycle();
        next_cycle();
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
    endtask

    initial begin
        int e;

        // Reset values
        #2 reset = 1'b1;
        next_cycle();
        next_cycle();
        chk("rst_state", int'(state), 0);
        chk("rst_clear_n", int'(timer_clear_n), 0);
        chk("rst_load_n", int'(timer_load_n), 1);
        chk("rst_enable_n", int'(timer_enable_n), 1);
        chk("rst_mag_on", int'(mag_on), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(timer_data), 0);
        reset = 1'b0;
        #1 chk("rel_clear_n_low", int'(timer_clear_n), 0);
        next_cycle();
        chk("rel_clear_n_high", int'(timer_clear_n), 1);
        mon_on = 1'b1;

        // Key entry: three digits load, the fourth and code 11 do not
        press_key(4'd1, 1'b1);
        zero = 1'b0;
        press_key(4'd2, 1'b1);
        press_key(4'd3, 1'b1);
        press_key(4'd4, 1'b0);
        press_key(4'd11, 1'b0);
        next_cycle();
        chk("key_state_set", int'(state), 1);
        chk("key_data_held", int'(timer_data), 3);
        sb_push(EV_CLR, 0, cyc + 3);
        push_button(2);
        chk("set_clear_idle", int'(state), 0);
        zero = 1'b1;

        // Start with timer at zero, in IDLE and in SET
        push_button(0);
        chk("idle_start_zero_state", int'(state), 0);
        chk("idle_start_zero_mag", int'(mag_on), 0);
        press_key(4'd0, 1'b1);
        push_button(0);
        chk("set_start_zero_state", int'(state), 1);
        sb_push(EV_CLR, 0, cyc + 3);
        push_button(2);
        chk("set_clear2_idle", int'(state), 0);

        // Cook to completion from 0:02
        press_key(4'd0, 1'b1);
        press_key(4'd0, 1'b1);
        press_key(4'd2, 1'b1);
        zero = 1'b0;
        e = cyc + 3;
        push_button(0);
        sb_push(EV_EN, 0, e + 4);
        sb_push(EV_EN, 0, e + 8);
        chk("cook_state", int'(state), 2);
        chk("cook_mag_on", int'(mag_on), 1);
        wait_until(e + 8);
        zero = 1'b1;
        sb_push(EV_DONE, 0, e + 9);
        next_cycle();
        chk("finish_state", int'(state), 0);
        chk("finish_mag_off", int'(mag_on), 0);
        repeat (6) next_cycle();

        // Zero rising in the tick cycle: done, no enable
        press_key(4'd7, 1'b1);
        zero = 1'b0;
        e = cyc + 3;
        push_button(0);
        wait_until(e + 3);
        zero = 1'b1;
        sb_push(EV_DONE, 0, e + 4);
        next_cycle();
        chk("tickzero_state", int'(state), 0);
        repeat (4) next_cycle();

        // Door interlock with prescaler hold and resume
        press_key(4'd1, 1'b1);
        zero = 1'b0;
        e = cyc + 3;
        push_button(0);
        wait_until(e + 2);
        door_closed = 1'b0;
        next_cycle();
        chk("door_pause_state", int'(state), 3);
        chk("door_mag_off", int'(mag_on), 0);
        push_button(0);
        chk("door_open_start_state", int'(state), 3);
        door_closed = 1'b1;
        next_cycle();
        e = cyc + 3;
        sb_push(EV_EN, 0, e + 2);
        push_button(0);
        chk("resume_state", int'(state), 2);
        chk("resume_mag_on", int'(mag_on), 1);
        wait_until(e + 2);
        zero = 1'b1;
        sb_push(EV_DONE, 0, e + 3);
        next_cycle();
        chk("resume_finish_state", int'(state), 0);

        // Stop in COOK, clear ignored in COOK, stop in PAUSE clears
        press_key(4'd5, 1'b1);
        zero = 1'b0;
        e = cyc + 3;
        push_button(0);
        sb_push(EV_EN, 0, e + 4);
        push_button(2);
        chk("cook_clear_ignored", int'(state), 2);
        push_button(1);
        chk("cook_stop_pause", int'(state), 3);
        chk("cook_stop_mag_off", int'(mag_on), 0);
        sb_push(EV_CLR, 0, cyc + 3);
        push_button(1);
        chk("pause_stop_idle", int'(state), 0);
        zero = 1'b1;
        repeat (3) next_cycle();

        // Asynchronous reset mid-COOK
        press_key(4'd8, 1'b1);
        zero = 1'b0;
        push_button(0);
        chk("prereset_mag_on", int'(mag_on), 1);
        mon_on = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_rst_mag_off", int'(mag_on), 0);
        chk("async_rst_state", int'(state), 0);
        next_cycle();
        reset = 1'b0;
        zero = 1'b1;
        next_cycle();

        chk("scoreboard_left", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
